// File: rtl/otter_fetch_pc_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response and the IR valid/ready register.
// master = fetch unit, slave = memory plus decode.
interface otter_fetch_pc_unit_if;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_GNT;
   logic        IMEM_RVALID;
   logic [31:0] IMEM_RDATA;
   logic        IR_VALID;
   logic        IR_READY;
   logic [31:0] IR;
   logic [31:0] IR_PC;

   modport master (
      output IMEM_REQ, IMEM_ADDR, IR_VALID, IR, IR_PC,
      input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA, IR_READY
   );

   modport slave (
      input  IMEM_REQ, IMEM_ADDR, IR_VALID, IR, IR_PC,
      output IMEM_GNT, IMEM_RVALID, IMEM_RDATA, IR_READY
   );
endinterface

// File: rtl/otter_fetch_pc_unit.sv
// OTTER fetch unit: PC register, one-outstanding imem handshake and IR valid/ready register.
// Define OTTER_FETCH_MISALIGN_TRAP_EN to trap (halt + MISALIGN pulse) on targets with bit 1 set.
module otter_fetch_pc_unit #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          REDIRECT,
   input  logic [1:0]                    PC_SOURCE,
   input  logic [31:0]                   JALR,
   input  logic [31:0]                   BRANCH,
   input  logic [31:0]                   JAL,
   input  logic [31:0]                   MTVEC,
   otter_fetch_pc_unit_if.master         bus,
   output logic                          MISALIGN
);

   typedef enum logic [2:0] {
      StReset,
      StReq,
      StWait,
      StOut
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
      , StHalt
`endif
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        kill_q, kill_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] ir_pc_q, ir_pc_d;
   logic        ir_valid_q, ir_valid_d;
   logic [31:0] sel;
   logic [31:0] target;

   always_comb begin
      case (PC_SOURCE)
         2'd0:    sel = JALR;
         2'd1:    sel = BRANCH;
         2'd2:    sel = JAL;
         default: sel = MTVEC;
      endcase
   end

`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;
   logic tgt_bad;
   assign target  = {sel[31:1], 1'b0};
   assign tgt_bad = sel[1];
`else
   assign target  = {sel[31:2], 2'b00};
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StReset;
         pc_q       <= RESET_VEC;
         req_pc_q   <= RESET_VEC;
         kill_q     <= 1'b0;
         ir_q       <= 32'h0;
         ir_pc_q    <= 32'h0;
         ir_valid_q <= 1'b0;
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         kill_q     <= kill_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      kill_d     = kill_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
      misalign_d = 1'b0;
`endif
      unique case (state_q)
         StReset: state_d = StReq;
         StReq: begin
            if (bus.IMEM_GNT) begin
               req_pc_d = pc_q;
               state_d  = StWait;
            end
         end
         StWait: begin
            if (bus.IMEM_RVALID) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = StReq;
               end else begin
                  ir_d       = bus.IMEM_RDATA;
                  ir_pc_d    = req_pc_q;
                  ir_valid_d = 1'b1;
                  pc_d       = req_pc_q + 32'd4;
                  state_d    = StOut;
               end
            end
         end
         StOut: begin
            if (bus.IR_READY) begin
               ir_valid_d = 1'b0;
               state_d    = StReq;
            end
         end
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
         StHalt: state_d = StHalt;
`endif
         default: state_d = StReq;
      endcase

      // Redirect overrides everything above; a response already on the bus this cycle is dropped.
      if (REDIRECT) begin
         ir_d       = ir_q;
         ir_pc_d    = ir_pc_q;
         ir_valid_d = 1'b0;
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
         if (tgt_bad) begin
            misalign_d = 1'b1;
            pc_d       = pc_q;
            kill_d     = 1'b0;
            state_d    = StHalt;
         end else
`endif
         begin
            pc_d   = target;
            // A request is still in flight if we are waiting, or it is being granted right now.
            kill_d = ((state_q == StWait) && !bus.IMEM_RVALID) ||
                     ((state_q == StReq) && bus.IMEM_GNT);
            state_d = kill_d ? StWait : StReq;
         end
      end
   end

   always_comb begin
      bus.IMEM_REQ  = (state_q == StReq);
      bus.IMEM_ADDR = pc_q;
      bus.IR_VALID  = ir_valid_q;
      bus.IR        = ir_q;
      bus.IR_PC     = ir_pc_q;
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
      MISALIGN      = misalign_q;
`else
      MISALIGN      = 1'b0;
`endif
   end

endmodule

// File: tb/tb_otter_fetch_pc_unit.sv
// Bench for otter_fetch_pc_unit: directed scenarios, then random traffic against an
// instruction-stream model (next fetch address = last delivered PC + 4, or the last redirect target).
module tb_otter_fetch_pc_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        REDIRECT = 1'b0;
   logic [1:0]  PC_SOURCE = 2'd0;
   logic [31:0] JALR = 32'h0, BRANCH = 32'h0, JAL = 32'h0, MTVEC = 32'h0;
   logic        MISALIGN;
   int          tests = 0;
   int          fails = 0;

   otter_fetch_pc_unit_if bus ();

   otter_fetch_pc_unit #(.RESET_VEC(32'h0000_0000)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REDIRECT  (REDIRECT),
      .PC_SOURCE (PC_SOURCE),
      .JALR      (JALR),
      .BRANCH    (BRANCH),
      .JAL       (JAL),
      .MTVEC     (MTVEC),
      .bus       (bus),
      .MISALIGN  (MISALIGN)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] ps, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
      case (ps)
         2'd0:    return a;
         2'd1:    return b;
         2'd2:    return c;
         default: return d;
      endcase
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      REDIRECT = 1'b0;
      bus.IMEM_GNT = 1'b0;
      bus.IMEM_RVALID = 1'b0;
      bus.IMEM_RDATA = 32'h0;
      bus.IR_READY = 1'b0;
      step();
      step();
      RST = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!bus.IMEM_REQ && n < 10) begin
         step();
         n++;
      end
      chk1("req_timeout", bus.IMEM_REQ, 1'b1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk1({tag, "_req"}, bus.IMEM_REQ, 1'b0);
      chk32({tag, "_addr"}, bus.IMEM_ADDR, 32'h0);
      chk1({tag, "_irv"}, bus.IR_VALID, 1'b0);
      chk32({tag, "_ir"}, bus.IR, 32'h0);
      chk32({tag, "_irpc"}, bus.IR_PC, 32'h0);
      chk1({tag, "_mis"}, MISALIGN, 1'b0);
   endtask

   // Zero-wait fetch at address a returning d; decode stalls for 'stall' cycles.
   task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int stall);
      wait_req();
      chk32("req_addr", bus.IMEM_ADDR, a);
      bus.IMEM_GNT = 1'b1;
      step();
      bus.IMEM_GNT = 1'b0;
      chk1("req_drop", bus.IMEM_REQ, 1'b0);
      bus.IMEM_RVALID = 1'b1;
      bus.IMEM_RDATA = d;
      step();
      bus.IMEM_RVALID = 1'b0;
      chk1("ir_valid", bus.IR_VALID, 1'b1);
      chk32("ir", bus.IR, d);
      chk32("ir_pc", bus.IR_PC, a);
      for (int i = 0; i < stall; i++) begin
         step();
         chk1("stall_valid", bus.IR_VALID, 1'b1);
         chk32("stall_ir", bus.IR, d);
         chk32("stall_ir_pc", bus.IR_PC, a);
         chk1("stall_noreq", bus.IMEM_REQ, 1'b0);
      end
      bus.IR_READY = 1'b1;
      step();
      bus.IR_READY = 1'b0;
      chk1("ir_valid_clr", bus.IR_VALID, 1'b0);
      chk1("next_req", bus.IMEM_REQ, 1'b1);
      chk32("next_addr", bus.IMEM_ADDR, a + 32'd4);
   endtask

   initial begin
      logic [31:0] nf, cur, oaddr;
      logic        prev_v, outst;
      int          delivered;

      // Reset values and first fetch.
      do_reset();
      chk_reset_vals("rst");
      fetch(32'h0, 32'h0000_0013, 0);

      // Three back-to-back fetches, decode stall on the second.
      do_reset();
      fetch(32'h0, 32'h1111_0001, 0);
      fetch(32'h4, 32'h2222_0002, 4);
      fetch(32'h8, 32'h3333_0003, 0);

      // Redirect while waiting; late response must be dropped.
      bus.IMEM_GNT = 1'b1;
      step();
      bus.IMEM_GNT = 1'b0;
      REDIRECT = 1'b1; PC_SOURCE = 2'd2; JAL = 32'h100;
      step();
      REDIRECT = 1'b0;
      step();
      bus.IMEM_RVALID = 1'b1; bus.IMEM_RDATA = 32'h0000_DEAD;
      step();
      bus.IMEM_RVALID = 1'b0;
      chk1("kill_irv", bus.IR_VALID, 1'b0);
      chk32("kill_ir", bus.IR, 32'h3333_0003);
      chk1("kill_req", bus.IMEM_REQ, 1'b1);
      chk32("kill_addr", bus.IMEM_ADDR, 32'h100);
      fetch(32'h100, 32'h4444_0004, 1);

      // Redirect coinciding with grant; JALR bit 0 cleared.
      bus.IMEM_GNT = 1'b1;
      REDIRECT = 1'b1; PC_SOURCE = 2'd0; JALR = 32'h205;
      step();
      bus.IMEM_GNT = 1'b0;
      REDIRECT = 1'b0;
      chk1("gntred_noreq", bus.IMEM_REQ, 1'b0);
      bus.IMEM_RVALID = 1'b1; bus.IMEM_RDATA = 32'h0000_0BAD;
      step();
      bus.IMEM_RVALID = 1'b0;
      chk1("gntred_irv", bus.IR_VALID, 1'b0);
      chk32("gntred_addr", bus.IMEM_ADDR, 32'h204);
      fetch(32'h204, 32'h5555_0005, 0);

      // PC wrap at the top of the address space.
      REDIRECT = 1'b1; PC_SOURCE = 2'd2; JAL = 32'hFFFF_FFFD;
      step();
      REDIRECT = 1'b0;
      chk32("wrap_tgt", bus.IMEM_ADDR, 32'hFFFF_FFFC);
      fetch(32'hFFFF_FFFC, 32'h6666_0006, 0);

      // Branch target with bit 1 set.
      REDIRECT = 1'b1; PC_SOURCE = 2'd1; BRANCH = 32'h302;
      step();
      REDIRECT = 1'b0;
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
      chk1("mis_pulse", MISALIGN, 1'b1);
      chk1("mis_noreq", bus.IMEM_REQ, 1'b0);
      step();
      chk1("mis_end", MISALIGN, 1'b0);
      chk1("halt_noreq", bus.IMEM_REQ, 1'b0);
      step();
      chk1("halt_noreq2", bus.IMEM_REQ, 1'b0);
      REDIRECT = 1'b1; PC_SOURCE = 2'd3; MTVEC = 32'h80;
      step();
      REDIRECT = 1'b0;
      chk1("trap_mis", MISALIGN, 1'b0);
      fetch(32'h80, 32'h7777_0007, 0);
`else
      chk1("mis_tied", MISALIGN, 1'b0);
      chk1("br_req", bus.IMEM_REQ, 1'b1);
      fetch(32'h300, 32'h7777_0007, 0);
`endif

      // Reset while a response is outstanding.
      bus.IMEM_GNT = 1'b1;
      step();
      bus.IMEM_GNT = 1'b0;
      RST = 1'b1;
      #1;
      chk_reset_vals("midrst");
      bus.IMEM_RVALID = 1'b1; bus.IMEM_RDATA = 32'h0000_BEEF;
      step();
      RST = 1'b0;
      step();
      chk1("postrst_irv", bus.IR_VALID, 1'b0);
      chk1("postrst_req", bus.IMEM_REQ, 1'b1);
      chk32("postrst_addr", bus.IMEM_ADDR, 32'h0);
      bus.IMEM_RVALID = 1'b0;
      step();
      chk1("postrst_irv2", bus.IR_VALID, 1'b0);
      fetch(32'h0, 32'h8888_0008, 0);

      // Random traffic against the instruction-stream model.
      do_reset();
      nf = 32'h0; cur = 32'h0; oaddr = 32'h0;
      prev_v = 1'b0; outst = 1'b0; delivered = 0;
      for (int c = 0; c < 3000; c++) begin
         if (bus.IMEM_REQ) chk32("rnd_addr", bus.IMEM_ADDR, nf);
         if (bus.IR_VALID && !prev_v) begin
            chk32("rnd_ir_pc", bus.IR_PC, nf);
            chk32("rnd_ir", bus.IR, mem(nf));
            cur = nf;
            nf = nf + 32'd4;
            delivered++;
         end else if (bus.IR_VALID) begin
            chk32("rnd_hold_pc", bus.IR_PC, cur);
            chk32("rnd_hold_ir", bus.IR, mem(cur));
         end
         prev_v = bus.IR_VALID;

         REDIRECT  = ($urandom_range(7) == 0);
         PC_SOURCE = 2'($urandom_range(3));
         JALR = $urandom; BRANCH = $urandom; JAL = $urandom; MTVEC = $urandom;
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
         JALR[1] = 1'b0; BRANCH[1] = 1'b0; JAL[1] = 1'b0; MTVEC[1] = 1'b0;
`endif
         bus.IMEM_GNT    = ($urandom_range(1) == 1);
         bus.IMEM_RVALID = outst && ($urandom_range(1) == 1);
         bus.IMEM_RDATA  = mem(oaddr);
         bus.IR_READY    = ($urandom_range(1) == 1);

         if (REDIRECT) nf = pick(PC_SOURCE, JALR, BRANCH, JAL, MTVEC) & ~32'h3;
         if (bus.IMEM_RVALID) outst = 1'b0;
         if (bus.IMEM_REQ && bus.IMEM_GNT) begin
            outst = 1'b1;
            oaddr = bus.IMEM_ADDR;
         end
         step();
      end
      chk1("rnd_progress", delivered >= 50, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/otter_fetch_pc_unit.md
Name: otter_fetch_pc_unit

Overview:
- Consumer end of the branch-target path: holds the OTTER program counter and issues instruction fetches.
- Accepts redirect targets (JALR, BRANCH, JAL, MTVEC) when the core signals a taken control transfer.
- Runs a one-outstanding-request handshake to instruction memory and presents each fetched instruction plus its PC to decode through a valid/ready register.
- Sits between the branch address generator / PC-source control and the decode stage.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
CLK  in  1  system clock; all state changes on rising edge
RST  in  1  reset, asynchronous, active-high
REDIRECT  in  1  taken control transfer this cycle; single-cycle qualifier for PC_SOURCE
PC_SOURCE  in  2  redirect select: 0 JALR, 1 BRANCH, 2 JAL, 3 MTVEC
JALR  in  32  jalr target
BRANCH  in  32  branch target
JAL  in  32  jal target
MTVEC  in  32  trap vector
IMEM_REQ  out  1  fetch request
IMEM_ADDR  out  32  fetch address
IMEM_GNT  in  1  request accepted this cycle
IMEM_RVALID  in  1  read data valid
IMEM_RDATA  in  32  instruction word
IR_VALID  out  1  IR/IR_PC hold a valid instruction
IR_READY  in  1  decode accepts IR this cycle
IR  out  32  fetched instruction
IR_PC  out  32  address of IR
MISALIGN  out  1  misaligned-target pulse; tied 0 unless the optional feature is enabled

Behaviour:
- Reset values: pc_q=RESET_VEC, state=S_RESET, kill=0, IMEM_REQ=0, IMEM_ADDR=RESET_VEC, IR_VALID=0, IR=32'h0, IR_PC=32'h0, MISALIGN=0.
- Reset asserted mid-operation forces these values immediately. A response to a pre-reset request is ignored: IMEM_RVALID is ignored in every state except S_WAIT.
- Target: sel = mux(PC_SOURCE). sel[0] is always cleared (JALR rule).
  - Feature off: sel[1] is also cleared, so every target is word aligned.
- IMEM_ADDR is always pc_q.
- IMEM_REQ = 1 only in S_REQ.
- States:
  - S_RESET: one cycle after reset release, no request, then go to S_REQ.
  - S_REQ: IMEM_REQ=1. On IMEM_GNT, capture req_pc=pc_q and go to S_WAIT.
  - S_WAIT: wait for IMEM_RVALID.
    - If kill=0: IR<=IMEM_RDATA, IR_PC<=req_pc, IR_VALID<=1, pc_q<=req_pc+4 (32-bit wrap, FFFF_FFFC+4 → 0), go to S_OUT.
    - If kill=1: discard the data, clear kill, go to S_REQ.
  - S_OUT: IR_VALID=1, outputs stable. On IR_READY, IR_VALID<=0 and go to S_REQ.
- REDIRECT handling (always highest priority, pc_q<=target):
  - S_RESET: load the target; still go to S_REQ.
  - S_REQ without GNT: the address changes the next cycle; IMEM_REQ stays high.
  - S_REQ with GNT in the same cycle: the old-address request is in flight; go to S_WAIT with kill=1.
  - S_WAIT: kill<=1. If IMEM_RVALID arrives in the same cycle, discard it and go directly to S_REQ.
  - S_OUT: IR_VALID<=0 and go to S_REQ. If IR_READY is high in the same cycle, the handshake still counts as completed.
- Latency:
  - Redirect in S_OUT: first request at the target on the next cycle.
  - Best-case throughput: 3 cycles per instruction (REQ+GNT, RVALID, READY) with a zero-wait-state memory.
- At most one request is outstanding. IMEM_GNT outside S_REQ is ignored.

Optional Feature:
- Macro: OTTER_FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Redirect target with sel[1]=1 does not load pc_q.
  - MISALIGN pulses high for 1 cycle; any in-flight response is killed and IR_VALID is cleared.
  - The unit enters S_HALT with IMEM_REQ=0 until the next REDIRECT, which loads its target (normally MTVEC) and goes to S_REQ.
  - A misaligned target in S_HALT re-pulses MISALIGN and stays in S_HALT.
- Undefined:
  - sel[1:0] is forced to 0, MISALIGN is constant 0, and S_HALT does not exist.

Test Plan:
- Reset release, memory GNT same cycle and RVALID next, RDATA=32'h0000_0013 → IMEM_ADDR 0x0, IR=0x13, IR_PC=0x0, then request at 0x4 after IR_READY.
- Three back-to-back fetches, IR_READY held low 4 cycles on the second → IR/IR_PC stable and IR_VALID high throughout the stall; addresses 0x0, 0x4, 0x8 in order.
- REDIRECT in S_WAIT with PC_SOURCE=2, JAL=0x100, RVALID 2 cycles later with 0xDEAD → 0xDEAD never appears on IR; next request at 0x100.
- REDIRECT with GNT in the same cycle, PC_SOURCE=0, JALR=0x205 → stale response discarded; next IMEM_ADDR=0x204 (macro off).
- Macro on: PC_SOURCE=1, BRANCH=0x302 → MISALIGN pulse, IMEM_REQ=0; then REDIRECT PC_SOURCE=3, MTVEC=0x80 → fetch at 0x80.
- RST asserted in S_WAIT, RVALID arrives during reset and in the first cycle after → all outputs at reset values, IR_VALID stays 0, first request at RESET_VEC.
